// File: rtl/fresh_fill_ctrl.sv
// -----------------------------------------------------------------------------
// fresh_fill_ctrl
//
// Drains inclusive address-range descriptors from a standard-mode FIFO and
// sweeps each range into a 1-bit-wide freshness BRAM, one address per cycle.
// Also performs a whole-memory zero-fill on request and gates the BRAM read
// port so ingredient queries are only admitted while the memory image is
// coherent (idle, nothing queued, no clear pending or being requested).
//
// Ports
//   clk, rst_n          sole clock, asynchronous active-low reset
//   rng_empty           FIFO empty flag
//   rng_rd_en           FIFO read strobe (data valid the following cycle)
//   rng_low, rng_high   range bounds, both inclusive
//   rng_fresh           value written across the range
//   clr_req             single-cycle zero-fill request
//   q_valid, q_addr     query request / address
//   q_ready             query accept (combinational)
//   r_valid, r_fresh    query response, two cycles after acceptance
//   ram_wr_en/addr/val  BRAM write port
//   ram_rd_addr         BRAM read address
//   ram_rd_val          BRAM read data, one cycle latency
//   busy                FSM active or clear pending
//   err_range           sticky: a descriptor with low > high was seen
//   ranges_done         saturating count of descriptors consumed
// -----------------------------------------------------------------------------
module fresh_fill_ctrl #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              rng_empty,
    output logic              rng_rd_en,
    input  logic [ADDR_W-1:0] rng_low,
    input  logic [ADDR_W-1:0] rng_high,
    input  logic              rng_fresh,

    input  logic              clr_req,

    input  logic              q_valid,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_ready,
    output logic              r_valid,
    output logic              r_fresh,

    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_wr_val,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic              ram_rd_val,

    output logic              busy,
    output logic              err_range,
    output logic [CNT_W-1:0]  ranges_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StFill,
        StClear
    } state_e;

    state_e state_q, state_d;

    // Sweep pointer, shared by range fills and the whole-memory clear.
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              val_q, val_d;
    logic              clr_pend_q, clr_pend_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  done_q, done_d;

    // Read-address hold register and the two-stage response pipeline.
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              acc_q, acc_d;
    logic              r_valid_q, r_valid_d;
    logic              r_fresh_q, r_fresh_d;

    logic              q_accept;
    logic              range_bad;

    assign range_bad = (rng_low > rng_high);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A clear (pending or arriving now) wins over the FIFO.
                if (clr_pend_q || clr_req) begin
                    state_d = StClear;
                end else if (!rng_empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                if (range_bad) begin
                    state_d = StIdle;
                end else begin
                    state_d = StFill;
                end
            end
            StFill: begin
                // Compare before increment so a range ending at the top
                // address terminates instead of wrapping to zero.
                if (cur_q == end_q) begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (cur_q == '1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        rng_rd_en   = 1'b0;
        q_ready     = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_val  = 1'b0;
        ram_wr_addr = cur_q;
        busy        = (state_q != StIdle) || clr_pend_q;
        unique case (state_q)
            StIdle: begin
                // clr_req is folded in so a same-cycle request blocks both
                // the FIFO pop and any query against a soon-stale image.
                q_ready   = rng_empty && !clr_pend_q && !clr_req;
                rng_rd_en = !rng_empty && !clr_pend_q && !clr_req;
            end
            StFill: begin
                ram_wr_en  = 1'b1;
                ram_wr_val = val_q;
            end
            StClear: begin
                ram_wr_en  = 1'b1;
                ram_wr_val = 1'b0;
            end
            default: ;
        endcase
    end

    assign q_accept    = q_valid && q_ready;
    // Combinational so the BRAM samples the address at the accept edge.
    assign ram_rd_addr = q_accept ? q_addr : rd_addr_q;

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        cur_d      = cur_q;
        end_d      = end_q;
        val_d      = val_q;
        err_d      = err_q;
        done_d     = done_q;
        clr_pend_d = clr_pend_q;

        // A request during a clear sweep is absorbed by that sweep.
        if (clr_req && (state_q != StClear)) begin
            clr_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (clr_pend_q || clr_req) begin
                    cur_d = '0;
                end
            end
            StLatch: begin
                cur_d = rng_low;
                end_d = rng_high;
                val_d = rng_fresh;
                if (done_q != '1) begin
                    done_d = done_q + CNT_W'(1);
                end
                if (range_bad) begin
                    err_d = 1'b1;
                end
            end
            StFill: begin
                if (cur_q != end_q) begin
                    cur_d = cur_q + ADDR_W'(1);
                end
            end
            StClear: begin
                if (cur_q == '1) begin
                    clr_pend_d = 1'b0;
                end else begin
                    cur_d = cur_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_addr_d = q_accept ? q_addr : rd_addr_q;
        acc_d     = q_accept;
        r_valid_d = acc_q;
        r_fresh_d = ram_rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q      <= '0;
            end_q      <= '0;
            val_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= '0;
            clr_pend_q <= 1'b0;
            rd_addr_q  <= '0;
            acc_q      <= 1'b0;
            r_valid_q  <= 1'b0;
            r_fresh_q  <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            end_q      <= end_d;
            val_q      <= val_d;
            err_q      <= err_d;
            done_q     <= done_d;
            clr_pend_q <= clr_pend_d;
            rd_addr_q  <= rd_addr_d;
            acc_q      <= acc_d;
            r_valid_q  <= r_valid_d;
            r_fresh_q  <= r_fresh_d;
        end
    end

    assign err_range   = err_q;
    assign ranges_done = done_q;
    assign r_valid     = r_valid_q;
    assign r_fresh     = r_fresh_q;

endmodule

// File: tb/tb_fresh_fill_ctrl.sv
// Bench for fresh_fill_ctrl with a 128-entry memory (ADDR_W = 7). A FIFO
// model and a read-first BRAM model form the plant; expectations come from a
// reference image updated from the descriptors and clears the bench issues.
module tb_fresh_fill_ctrl;

    localparam int unsigned AW    = 7;
    localparam int unsigned CW    = 16;
    localparam int          Depth = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          rng_empty;
    logic          rng_rd_en;
    logic [AW-1:0] rng_low;
    logic [AW-1:0] rng_high;
    logic          rng_fresh;
    logic          clr_req;
    logic          q_valid;
    logic [AW-1:0] q_addr;
    logic          q_ready;
    logic          r_valid;
    logic          r_fresh;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_wr_val;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_val;
    logic          busy;
    logic          err_range;
    logic [CW-1:0] ranges_done;

    fresh_fill_ctrl #(
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rng_empty   (rng_empty),
        .rng_rd_en   (rng_rd_en),
        .rng_low     (rng_low),
        .rng_high    (rng_high),
        .rng_fresh   (rng_fresh),
        .clr_req     (clr_req),
        .q_valid     (q_valid),
        .q_addr      (q_addr),
        .q_ready     (q_ready),
        .r_valid     (r_valid),
        .r_fresh     (r_fresh),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_val  (ram_wr_val),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_val  (ram_rd_val),
        .busy        (busy),
        .err_range   (err_range),
        .ranges_done (ranges_done)
    );

    typedef struct packed {
        logic [AW-1:0] low;
        logic [AW-1:0] high;
        logic          fresh;
    } desc_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          val;
    } wr_t;

    typedef struct {
        int   k;
        logic exp;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] low;
        logic [AW-1:0] high;
        logic          fresh;
        int            n_wr;
        logic          err;
    } vec_t;

    desc_t fifo[$];
    wr_t   wlog[$];
    rsp_t  rsp_q[$];
    rsp_t  rsp_cur;
    logic  bram[Depth];
    logic  ref_mem[Depth];
    vec_t  vecs[7];
    logic [AW-1:0] qa[4];

    int checks;
    int failures;
    int k;
    int busy_cnt;
    int acc_cnt;
    int last_wr_k;
    int first_acc_k;
    int exp_done;
    int base;

    logic          s_rd_en;
    logic          s_wr_en;
    logic          s_wr_val;
    logic [AW-1:0] s_wr_addr;
    logic [AW-1:0] s_rd_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sampler: one sample per cycle, 1 time unit before the rising edge.
    initial begin
        k = 0;
        forever begin
            @(negedge clk);
            #4;
            s_rd_en   = rng_rd_en;
            s_wr_en   = ram_wr_en;
            s_wr_addr = ram_wr_addr;
            s_wr_val  = ram_wr_val;
            s_rd_addr = ram_rd_addr;
            if (busy) busy_cnt++;
            if (q_valid && q_ready) begin
                acc_cnt++;
                if (first_acc_k < 0) first_acc_k = k;
                rsp_q.push_back('{k, ref_mem[q_addr]});
            end
            if (r_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(r_valid), 0);
                end else begin
                    rsp_cur = rsp_q.pop_front();
                    check("rsp_latency", k - rsp_cur.k, 2);
                    check("rsp_fresh", 32'(r_fresh), 32'(rsp_cur.exp));
                end
            end
            k++;
        end
    end

    // Plant: BRAM (read-first, 1-cycle latency) and standard-mode FIFO.
    always @(posedge clk) begin
        if (s_wr_en) begin
            bram[s_wr_addr] <= s_wr_val;
            wlog.push_back('{s_wr_addr, s_wr_val});
            last_wr_k <= k - 1;
        end
        ram_rd_val <= bram[s_rd_addr];
        if (s_rd_en && fifo.size() > 0) begin
            rng_low   <= fifo[0].low;
            rng_high  <= fifo[0].high;
            rng_fresh <= fifo[0].fresh;
            rng_empty <= (fifo.size() == 1);
            void'(fifo.pop_front());
        end
    end

    task automatic push(input logic [AW-1:0] l, input logic [AW-1:0] h, input logic f,
                        input bit upd);
        fifo.push_back('{l, h, f});
        rng_empty = 1'b0;
        exp_done++;
        if (upd && l <= h) begin
            for (int a = int'(l); a <= int'(h); a++) ref_mem[a] = f;
        end
    endtask

    task automatic clear_ref();
        for (int a = 0; a < Depth; a++) ref_mem[a] = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < Depth; a++) begin
            if (bram[a] !== ref_mem[a]) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && rng_empty == 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        busy_cnt    = 0;
        acc_cnt     = 0;
        last_wr_k   = -10;
        first_acc_k = -1;
        exp_done    = 0;
        rng_empty   = 1'b1;
        rng_low     = '0;
        rng_high    = '0;
        rng_fresh   = 1'b0;
        clr_req     = 1'b0;
        q_valid     = 1'b0;
        q_addr      = '0;
        ram_rd_val  = 1'b0;
        for (int a = 0; a < Depth; a++) begin
            bram[a]    = 1'b0;
            ref_mem[a] = 1'b0;
        end

        // {low, high, fresh, expected writes, expected sticky err}
        vecs[0] = '{7'd5,   7'd8,   1'b1, 4, 1'b0};
        vecs[1] = '{7'd126, 7'd127, 1'b1, 2, 1'b0};
        vecs[2] = '{7'd9,   7'd3,   1'b1, 0, 1'b1};
        vecs[3] = '{7'd3,   7'd3,   1'b1, 1, 1'b1};
        vecs[4] = '{7'd6,   7'd7,   1'b0, 2, 1'b1};
        vecs[5] = '{7'd127, 7'd127, 1'b0, 1, 1'b1};
        vecs[6] = '{7'd0,   7'd2,   1'b1, 3, 1'b1};
        qa[0] = 7'd4;
        qa[1] = 7'd5;
        qa[2] = 7'd8;
        qa[3] = 7'd9;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ctl", 32'({rng_rd_en, ram_wr_en, ram_wr_val, r_valid, r_fresh, busy,
                              err_range}), 0);
        check("rst_wr_addr", 32'(ram_wr_addr), 0);
        check("rst_rd_addr", 32'(ram_rd_addr), 0);
        check("rst_done", 32'(ranges_done), 0);
        check("rst_q_ready", 32'(q_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven ranges, each run to completion.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            base     = wlog.size();
            busy_cnt = 0;
            push(vecs[i].low, vecs[i].high, vecs[i].fresh, 1'b1);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d_wr_cnt", i), wlog.size() - base, vecs[i].n_wr);
            if (vecs[i].n_wr > 0 && wlog.size() > base) begin
                check($sformatf("vec%0d_first", i), 32'(wlog[base].addr), 32'(vecs[i].low));
                check($sformatf("vec%0d_last", i), 32'(wlog[wlog.size() - 1].addr),
                      32'(vecs[i].high));
            end
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, 2 + vecs[i].n_wr);
            check($sformatf("vec%0d_err", i), 32'(err_range), 32'(vecs[i].err));
            check($sformatf("vec%0d_done", i), 32'(ranges_done), exp_done);
            check_mem($sformatf("vec%0d_mem", i));
        end

        // Back-to-back queries: addresses 4,5,8,9 read 0,1,1,0.
        base = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            q_valid = 1'b1;
            q_addr  = qa[i];
        end
        @(negedge clk);
        q_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("q_accepts", acc_cnt - base, 4);
        check("q_drained", rsp_q.size(), 0);

        // Clear requested during the 3rd FILL cycle of a full-memory range,
        // plus a second request mid-clear that must be absorbed.
        @(negedge clk);
        base = wlog.size();
        push(7'd0, 7'd127, 1'b1, 1'b1);
        for (int n = 0; n < 50 && !(ram_wr_en && ram_wr_addr == 7'd2); n++) @(negedge clk);
        check("cf_third_fill", 32'(ram_wr_addr), 2);
        clr_req = 1'b1;
        clear_ref();
        @(negedge clk);
        clr_req = 1'b0;
        for (int n = 0; n < 400 && (wlog.size() - base) < 148; n++) @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_idle("cf");
        check("cf_wr_cnt", wlog.size() - base, 256);
        begin
            int bad;
            bad = 0;
            for (int j = 0; j < 256 && base + j < wlog.size(); j++) begin
                if (wlog[base + j].addr !== 7'(j % 128) || wlog[base + j].val !== (j < 128))
                    bad++;
            end
            check("cf_sequence", bad, 0);
        end
        check_mem("cf_mem");
        @(negedge clk);
        q_valid = 1'b1;
        q_addr  = 7'd7;
        @(negedge clk);
        q_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("cf_query_drained", rsp_q.size(), 0);

        // Clear request and a non-empty FIFO together in IDLE: clear first.
        @(negedge clk);
        base = wlog.size();
        push(7'd20, 7'd21, 1'b1, 1'b0);
        clr_req = 1'b1;
        clear_ref();
        ref_mem[20] = 1'b1;
        ref_mem[21] = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wait_idle("sim");
        check("sim_wr_cnt", wlog.size() - base, 130);
        if (wlog.size() >= base + 130) begin
            check("sim_first_val", 32'(wlog[base].val), 0);
            check("sim_fill_addr", 32'(wlog[base + 128].addr), 20);
        end
        check_mem("sim_mem");

        // Query held high while two ranges are queued.
        @(negedge clk);
        base        = wlog.size();
        first_acc_k = -1;
        q_valid     = 1'b1;
        q_addr      = 7'd5;
        push(7'd0, 7'd10, 1'b1, 1'b1);
        push(7'd5, 7'd5, 1'b0, 1'b1);
        for (int n = 0; n < 200 && first_acc_k < 0; n++) @(negedge clk);
        q_valid = 1'b0;
        check("gate_accept_cycle", first_acc_k, last_wr_k + 1);
        check("gate_wr_cnt", wlog.size() - base, 12);
        repeat (4) @(negedge clk);
        check("gate_drained", rsp_q.size(), 0);
        check_mem("gate_mem");

        // Asynchronous reset at the 10th FILL cycle of {0, 100, 1}.
        @(negedge clk);
        base = wlog.size();
        push(7'd0, 7'd100, 1'b1, 1'b0);
        for (int n = 0; n < 50 && !(ram_wr_en && ram_wr_addr == 7'd9); n++) @(negedge clk);
        check("rm_tenth_fill", 32'(ram_wr_addr), 9);
        rst_n = 1'b0;
        #1;
        check("rm_ctl", 32'({rng_rd_en, ram_wr_en, ram_wr_val, r_valid, busy, err_range}), 0);
        check("rm_wr_addr", 32'(ram_wr_addr), 0);
        check("rm_done", 32'(ranges_done), 0);
        check("rm_q_ready", 32'(q_ready), 1);
        exp_done = 0;
        for (int a = 0; a <= 8; a++) ref_mem[a] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rm_wr_cnt", wlog.size() - base, 9);
        check("rm_busy", 32'(busy), 0);
        check("rm_done_after", 32'(ranges_done), exp_done);
        check_mem("rm_mem");

        repeat (3) @(negedge clk);
        check("rsp_pending", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fresh_fill_ctrl.md
# fresh_fill_ctrl

Single-clock controller that drains range descriptors from the read side of the range FIFO and sequences them into the 1-bit freshness BRAM as inclusive address sweeps. It also runs a whole-memory clear on request and arbitrates the BRAM read port for ingredient queries, admitting a query only when the memory image is coherent. It sits between the FIFO read port, the `sdp_bram` instance and the query front end.

## Interface

**Parameters**
- `ADDR_W`, 17: BRAM address width; the memory holds 2^ADDR_W one-bit entries.
- `CNT_W`, 16: width of the processed-range counter.

**Ports**
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rng_empty` in 1: FIFO empty flag.
- `rng_rd_en` out 1: FIFO read strobe. Standard mode: data is valid the cycle after the strobe.
- `rng_low` in ADDR_W: range start, inclusive.
- `rng_high` in ADDR_W: range end, inclusive.
- `rng_fresh` in 1: value to write across the range.
- `clr_req` in 1: single-cycle pulse requesting a zero-fill of the whole memory.
- `q_valid` in 1: query request.
- `q_addr` in ADDR_W: query address.
- `q_ready` out 1: query accept. A query is accepted when `q_valid & q_ready`.
- `r_valid` out 1: query response strobe.
- `r_fresh` out 1: query result.
- `ram_wr_en`, `ram_wr_addr`, `ram_wr_val` out 1/ADDR_W/1: BRAM write port.
- `ram_rd_addr` out ADDR_W: BRAM read address.
- `ram_rd_val` in 1: BRAM read data, one cycle of latency.
- `busy` out 1: high whenever the FSM is not in IDLE or a clear is pending.
- `err_range` out 1: sticky flag, set when a descriptor with low > high is received.
- `ranges_done` out CNT_W: count of descriptors consumed; saturates at all-ones.

## Operation

**FSM states:** IDLE, FETCH, LATCH, FILL, CLEAR.

**IDLE**
- If a clear is pending (`clr_pend`), go to CLEAR with `ram_wr_addr` = 0.
- Otherwise, if `!rng_empty`, assert `rng_rd_en` for one cycle and go to FETCH.
- A pending clear has priority over the FIFO.

**FETCH:** wait state; FIFO data becomes valid at the end of this cycle. Go to LATCH.

**LATCH:** capture `rng_low`, `rng_high` and `rng_fresh` into `cur`, `end` and `val`. Increment `ranges_done`.
- If low > high: set `err_range`, issue no writes, go to IDLE.
- Otherwise go to FILL.

**FILL:** `ram_wr_en` = 1, `ram_wr_addr` = `cur`, `ram_wr_val` = `val`.
- If `cur == end`, go to IDLE.
- Otherwise `cur <= cur + 1`.
- The equality test happens before the increment, so `end` = 2^ADDR_W−1 terminates without wrapping to 0.

**CLEAR:** write 0 to `ram_wr_addr` starting at address 0 and incrementing each cycle.
- The last write is to address 2^ADDR_W−1; then clear `clr_pend` and go to IDLE.

**Clear requests:** `clr_req` sets `clr_pend` in any state.
- A request arriving during FILL takes effect only after the current range completes; ranges are never truncated.
- A `clr_req` seen during CLEAR is absorbed and does not trigger a second sweep.

**Query gating**
- `q_ready = (state == IDLE) & !clr_pend & rng_empty & !clr_req` (combinational).
- `ram_rd_addr = q_addr` when a query is accepted. Otherwise it holds its last value.

**Query pipeline:** fully pipelined, one query per cycle.
- `r_valid` is asserted exactly 2 cycles after acceptance.
- `r_fresh` is the registered `ram_rd_val`.
- Responses are returned in order.
- `q_ready` falling does not cancel in-flight responses.

## Timing

**Reset values:** `rng_rd_en`, `ram_wr_en`, `ram_wr_addr`, `ram_wr_val`, `ram_rd_addr`, `r_valid`, `r_fresh`, `busy`, `err_range` and `ranges_done` are all 0. State is IDLE and `clr_pend` is 0.
- `q_ready` follows `rng_empty` during reset.

**Range throughput:** a range of N addresses occupies 3+N cycles (IDLE strobe, FETCH, LATCH, N×FILL). Back-to-back ranges add 1 IDLE cycle between them.

**Clear duration:** 2^ADDR_W write cycles plus 1 IDLE cycle.

**Write-to-query coherence:** the final FILL/CLEAR write at cycle W is followed by IDLE at W+1. A query accepted at W+1 reads the updated entry, because the BRAM commits at the W→W+1 edge.

**Reset mid-operation:** `rst_n` low forces the reset values immediately.
- A partial fill or clear is abandoned and not resumed.
- The FIFO descriptor in flight is lost.

**Simultaneous events:** `clr_req` together with `!rng_empty` in IDLE → CLEAR first, then FIFO.

## Test plan

- **Single range.** Reset, push {low=5, high=8, fresh=1}.
  - Required: `ram_wr_en` high for exactly 4 cycles at addresses 5,6,7,8.
  - Required: `ranges_done` = 1.
  - Required: queries to 4, 5, 8 and 9 return 0, 1, 1, 0 with `r_valid` 2 cycles after each accept.
- **Top-of-memory range.** `ADDR_W`=4, range {14, 15, 1}.
  - Required: writes at 14 and 15 only, with no write to 0.
  - Required: FSM back in IDLE after 5 cycles.
- **Invalid range.** Range {9, 3, 1}.
  - Required: zero writes, `err_range` = 1 and stays high.
  - Required: `ranges_done` increments.
  - Required: the following valid range {3, 3, 1} still writes address 3.
- **Clear during fill.** `ADDR_W`=4, range {0, 15, 1}, `clr_req` pulsed at the 3rd FILL cycle.
  - Required: all 16 fill writes complete, then 16 zero writes at 0..15.
  - Required: a query to 7 afterwards returns 0.
- **Query gating.** Hold `q_valid` high with `q_addr`=5 while 2 ranges are queued.
  - Required: `q_ready` stays 0 until the last FILL completes.
  - Required: the first accepted query returns the final written value of address 5.
- **Async reset mid-fill.** Range {0, 100, 1}, drop `rst_n` at the 10th FILL cycle.
  - Required: outputs are at their reset values within the same cycle.
  - Required: no further writes occur.
  - Required: after release, `busy` = 0 with an empty FIFO.
